// File: rtl/xhdmiin_align_ctrl.sv
// TMDS lane calibration: sweeps delay tap and word shift, scores control-token hits,
// centres the delay on the widest good eye and tracks lock on the aligned word.
//
// state   | meaning
// BOOT    | deserializer held off (o_ce=0) for 4 cycles
// LOAD    | o_delay driven, waiting for readback to match
// SETTLE  | fixed wait after the tap has taken effect
// MEASURE | counting control tokens over one window
// EVAL    | score the tap, extend or close the current run
// DECIDE  | lock onto best eye, or advance the word shift
// LOCKED  | tracking; too long without a token restarts the scan
module xhdmiin_align_ctrl #(
  parameter int SETTLE  = 16,
  parameter int LGWIN   = 12,
  parameter int THRESH  = 16,
  parameter int MIN_EYE = 4,
  parameter int LGLOSS  = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [9:0] i_word,
  input  logic [4:0] i_delay_rb,
  output logic       o_ce,
  output logic [4:0] o_delay,
  output logic [3:0] o_shift,
  output logic [9:0] o_word,
  output logic       o_locked,
  output logic [4:0] o_eye_start,
  output logic [5:0] o_eye_len
);

  localparam logic [2:0] S_BOOT    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_EVAL    = 3'd4;
  localparam logic [2:0] S_DECIDE  = 3'd5;
  localparam logic [2:0] S_LOCKED  = 3'd6;

  localparam int SW    = $clog2(SETTLE + 1);
  localparam int TMR_W = (LGWIN > SW) ? ((LGWIN > 3) ? LGWIN : 3) : ((SW > 3) ? SW : 3);

  localparam logic [TMR_W-1:0]  BOOT_LAST   = TMR_W'(3);
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0]  WIN_LAST    = TMR_W'({LGWIN{1'b1}});
  localparam logic [LGLOSS-1:0] LOSS_LAST   = {LGLOSS{1'b1}};

  logic [2:0]        state;
  logic [TMR_W-1:0]  tmr;
  logic [LGWIN:0]    tok_cnt;
  logic [LGLOSS-1:0] loss_cnt;
  logic [4:0]        tap;
  logic [4:0]        run_start, best_start;
  logic [5:0]        run_len, best_len;
  logic              lock_pend;

  logic [9:0]  r_prev;
  logic [19:0] cat;
  logic [9:0]  aligned;
  logic        tok;
  logic        good;
  logic [4:0]  run_start_n, best_start_n;
  logic [5:0]  run_len_n, best_len_n;

  assign cat     = {i_word, r_prev};
  assign aligned = 10'(cat >> o_shift);
  assign tok     = (aligned == 10'h354) || (aligned == 10'h0AB) ||
                   (aligned == 10'h154) || (aligned == 10'h2AB);
  assign good    = (int'(tok_cnt) >= THRESH);

  always_ff @(posedge i_clk) r_prev <= i_word;

  always_ff @(posedge i_clk) begin
    if (i_reset) o_word <= 10'd0;
    else         o_word <= aligned;
  end

  // Run bookkeeping for EVAL; on the last tap an open run is still a candidate.
  always_comb begin
    run_start_n  = run_start;
    run_len_n    = run_len;
    best_start_n = best_start;
    best_len_n   = best_len;
    if (good) begin
      if (run_len == 6'd0) run_start_n = tap;
      run_len_n = run_len + 6'd1;
    end else begin
      if (run_len > best_len) begin
        best_start_n = run_start;
        best_len_n   = run_len;
      end
      run_len_n = 6'd0;
    end
    if ((tap == 5'd31) && (run_len_n > best_len_n)) begin
      best_start_n = run_start_n;
      best_len_n   = run_len_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_BOOT;
      tmr         <= BOOT_LAST;
      tok_cnt     <= '0;
      loss_cnt    <= LOSS_LAST;
      tap         <= 5'd0;
      run_start   <= 5'd0;
      run_len     <= 6'd0;
      best_start  <= 5'd0;
      best_len    <= 6'd0;
      lock_pend   <= 1'b0;
      o_ce        <= 1'b0;
      o_delay     <= 5'd0;
      o_shift     <= 4'd0;
      o_locked    <= 1'b0;
      o_eye_start <= 5'd0;
      o_eye_len   <= 6'd0;
    end else begin
      case (state)
        S_BOOT: begin
          if (tmr == '0) begin
            o_ce      <= 1'b1;
            tap       <= 5'd0;
            o_delay   <= 5'd0;
            o_shift   <= 4'd0;
            run_len   <= 6'd0;
            best_len  <= 6'd0;
            lock_pend <= 1'b0;
            state     <= S_LOAD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_LOAD: begin
          if (i_delay_rb == o_delay) begin
            if (lock_pend) begin
              lock_pend <= 1'b0;
              o_locked  <= 1'b1;
              loss_cnt  <= LOSS_LAST;
              state     <= S_LOCKED;
            end else begin
              tmr   <= SETTLE_LAST;
              state <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (tmr == '0) begin
            tmr     <= WIN_LAST;
            tok_cnt <= '0;
            state   <= S_MEASURE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_MEASURE: begin
          if (tok && !tok_cnt[LGWIN]) tok_cnt <= tok_cnt + 1'b1;
          if (tmr == '0) state <= S_EVAL;
          else           tmr   <= tmr - 1'b1;
        end
        S_EVAL: begin
          run_start  <= run_start_n;
          run_len    <= run_len_n;
          best_start <= best_start_n;
          best_len   <= best_len_n;
          if (tap != 5'd31) begin
            tap     <= tap + 5'd1;
            o_delay <= tap + 5'd1;
            state   <= S_LOAD;
          end else begin
            state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (int'(best_len) >= MIN_EYE) begin
            o_eye_start <= best_start;
            o_eye_len   <= best_len;
            o_delay     <= best_start + best_len[5:1];
            lock_pend   <= 1'b1;
          end else begin
            o_shift  <= (o_shift == 4'd9) ? 4'd0 : o_shift + 4'd1;
            tap      <= 5'd0;
            o_delay  <= 5'd0;
            run_len  <= 6'd0;
            best_len <= 6'd0;
          end
          state <= S_LOAD;
        end
        S_LOCKED: begin
          if (tok) begin
            loss_cnt <= LOSS_LAST;
          end else if (loss_cnt == '0) begin
            o_locked <= 1'b0;
            tap      <= 5'd0;
            o_delay  <= 5'd0;
            o_shift  <= 4'd0;
            run_len  <= 6'd0;
            best_len <= 6'd0;
            state    <= S_LOAD;
          end else begin
            loss_cnt <= loss_cnt - 1'b1;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_xhdmiin_align_ctrl.sv
// Directed bench for xhdmiin_align_ctrl: a tap-dependent lane model feeds the DUT,
// a sweep-level eye model predicts lock results, and o_word is checked every cycle.
module tb_xhdmiin_align_ctrl;

  localparam int P_SETTLE  = 2;
  localparam int P_LGWIN   = 4;
  localparam int P_THRESH  = 8;
  localparam int P_MIN_EYE = 4;
  localparam int P_LGLOSS  = 6;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [9:0] i_word;
  logic [4:0] i_delay_rb;
  logic       o_ce;
  logic [4:0] o_delay;
  logic [3:0] o_shift;
  logic [9:0] o_word;
  logic       o_locked;
  logic [4:0] o_eye_start;
  logic [5:0] o_eye_len;

  int checks   = 0;
  int failures = 0;

  logic        hold_rb, force_bad;
  logic [9:0]  pat;
  logic [31:0] mask;
  logic [9:0]  prev_drv = 10'd0;
  logic [9:0]  prev_chk = 10'd0;
  logic [9:0]  exp_word;

  xhdmiin_align_ctrl #(
    .SETTLE(P_SETTLE), .LGWIN(P_LGWIN), .THRESH(P_THRESH),
    .MIN_EYE(P_MIN_EYE), .LGLOSS(P_LGLOSS)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_word(i_word), .i_delay_rb(i_delay_rb),
    .o_ce(o_ce), .o_delay(o_delay), .o_shift(o_shift), .o_word(o_word),
    .o_locked(o_locked), .o_eye_start(o_eye_start), .o_eye_len(o_eye_len)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [9:0] next_bad(input logic [9:0] p);
    logic [9:0] w;
    logic clash;
    for (int tries = 0; tries < 1000; tries++) begin
      w = 10'($urandom);
      clash = 1'b0;
      for (int s = 0; s < 10; s++) if (is_tok(10'({w, p} >> s))) clash = 1'b1;
      if (!clash) return w;
    end
    return 10'h000;
  endfunction

  // Widest contiguous run of good taps; on equal length the lowest start wins.
  function automatic void best_eye(input logic [31:0] m, output int st, output int ln);
    st = 0;
    ln = 0;
    for (int a = 0; a < 32; a++) begin
      int l;
      l = 0;
      if (m[a] && (a == 0 || !m[a-1])) begin
        while (a + l < 32 && m[a+l]) l++;
        if (l > ln) begin
          ln = l;
          st = a;
        end
      end
    end
  endfunction

  // The repeated pattern seen through shift s is pat rotated right by s.
  task automatic predict(output int sh, output int st, output int ln, output int dly);
    int s0, l0;
    sh = -1; st = 0; ln = 0; dly = 0;
    for (int s = 0; s < 10 && sh < 0; s++) begin
      if (is_tok(10'({pat, pat} >> s))) begin
        best_eye(mask, s0, l0);
        if (l0 >= P_MIN_EYE) begin
          sh = s; st = s0; ln = l0; dly = s0 + l0 / 2;
        end
      end
    end
  endtask

  // Lane model: good taps carry the pattern, bad taps carry token-free data.
  always @(negedge i_clk) begin
    i_delay_rb = hold_rb ? ~o_delay : o_delay;
    if (!force_bad && mask[o_delay]) i_word = pat;
    else                             i_word = next_bad(prev_drv);
    prev_drv = i_word;
  end

  always @(posedge i_clk) begin
    exp_word = i_reset ? 10'd0 : 10'({i_word, prev_chk} >> o_shift);
    prev_chk = i_word;
    #1;
    chk("o_word", o_word, exp_word);
  end

  task automatic apply_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic wait_lock(input string nm, input int budget);
    int n;
    n = 0;
    while (o_locked !== 1'b1 && n < budget) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk({nm, "_lock_timeout"}, o_locked, 1);
  endtask

  task automatic lock_and_model(input string nm, input int budget);
    int sh, st, ln, dly;
    predict(sh, st, ln, dly);
    wait_lock(nm, budget);
    chk({nm, "_shift"}, o_shift, sh);
    chk({nm, "_eye_start"}, o_eye_start, st);
    chk({nm, "_eye_len"}, o_eye_len, ln);
    chk({nm, "_delay"}, o_delay, dly);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_word = 10'd0; i_delay_rb = 5'd0;
    hold_rb = 1'b0; force_bad = 1'b0;
    pat = 10'h354; mask = 32'h000F_FF00;

    @(posedge i_clk); #1;
    chk("rst_ce", o_ce, 0);
    chk("rst_delay", o_delay, 0);
    chk("rst_shift", o_shift, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_eye_start", o_eye_start, 0);
    chk("rst_eye_len", o_eye_len, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge i_clk); #1;
      chk("boot_ce", o_ce, (k >= 4) ? 1 : 0);
    end

    // Single eye 8..19 at shift 0
    lock_and_model("t1", 5000);
    chk("t1_eye_start_lit", o_eye_start, 8);
    chk("t1_eye_len_lit", o_eye_len, 12);
    chk("t1_delay_lit", o_delay, 14);
    chk("t1_shift_lit", o_shift, 0);

    // Two equal eyes: earlier one wins
    mask = 32'h01F0_007C;
    apply_reset();
    lock_and_model("t2", 5000);
    chk("t2_eye_start_lit", o_eye_start, 2);
    chk("t2_delay_lit", o_delay, 4);

    // Eye touching the last tap
    mask = 32'hF800_0000;
    apply_reset();
    lock_and_model("t2b", 5000);
    chk("t2b_eye_start_lit", o_eye_start, 27);
    chk("t2b_eye_len_lit", o_eye_len, 5);
    chk("t2b_delay_lit", o_delay, 29);

    // Tokens offset by 3 bits: pattern is 354 rotated left by 3
    pat = 10'h2A6;
    mask = 32'hFFFF_FFFF;
    apply_reset();
    lock_and_model("t3", 9000);
    chk("t3_shift_lit", o_shift, 3);
    chk("t3_eye_start_lit", o_eye_start, 0);
    chk("t3_eye_len_lit", o_eye_len, 32);
    chk("t3_delay_lit", o_delay, 16);
    @(posedge i_clk); #1;
    chk("t3_word_lit", o_word, 10'h354);

    // Loss of lock after 2^LGLOSS token-free words
    #1 force_bad = 1'b1;
    for (int k = 1; k <= (1 << P_LGLOSS); k++) begin
      @(posedge i_clk); #1;
      if (k == (1 << P_LGLOSS) - 1) chk("loss_still_locked", o_locked, 1);
    end
    chk("loss_locked_fall", o_locked, 0);
    chk("loss_shift", o_shift, 0);
    chk("loss_delay", o_delay, 0);
    repeat (5) @(posedge i_clk);
    #1;
    chk("loss_eye_start_hold", o_eye_start, 0);
    chk("loss_eye_len_hold", o_eye_len, 32);
    chk("loss_relock", o_locked, 0);
    force_bad = 1'b0;

    // Readback mismatch stalls in LOAD; then reset in the middle of MEASURE
    pat = 10'h354;
    hold_rb = 1'b1;
    apply_reset();
    repeat (60) @(posedge i_clk);
    #1;
    chk("hold_ce", o_ce, 1);
    chk("hold_delay", o_delay, 0);
    chk("hold_locked", o_locked, 0);
    @(negedge i_clk);
    hold_rb = 1'b0;
    begin
      int n;
      n = 0;
      while (o_delay !== 5'd1 && n < 100) begin
        @(posedge i_clk); #1;
        n++;
      end
      chk("hold_release_advance", o_delay, 1);
    end
    repeat (8) @(posedge i_clk);
    #1;
    chk("pre_rst_ce", o_ce, 1);
    chk("pre_rst_word", o_word, 10'h354);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    chk("mid_rst_ce", o_ce, 0);
    chk("mid_rst_delay", o_delay, 0);
    chk("mid_rst_shift", o_shift, 0);
    chk("mid_rst_word", o_word, 0);
    chk("mid_rst_locked", o_locked, 0);
    chk("mid_rst_eye_start", o_eye_start, 0);
    chk("mid_rst_eye_len", o_eye_len, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
